multicycle_control_sequencer: RTL and testbench
===============================================

// Module: multicycle_control_sequencer
// PURPOSE
//  Parametrised control sequencer for the multicycle CPU. Takes the one-hot opcode
//  from the opcode decoder and the flags register, and steps each instruction
//  through FETCH, DECODE and 1..MAX_STEPS execute steps. It drives the datapath
//  control word each cycle. Adds flag-qualified branches, single-step mode and
//  illegal-opcode trapping.
// PARAMETERS
//  NUM_OPS    23  number of one-hot opcode lines
//  CTRL_W     23  control word width, ctrl[CTRL_W:1]
//  FLAG_W     4   flags register width
//  MAX_STEPS  4   max execute steps per instruction; step counter width = $clog2(MAX_STEPS)
// PORTS
//  clock       in   1          system clock, rising edge
//  reset       in   1          asynchronous, active-high
//  run         in   1          level; 1 = fetch and execute instructions
//  step_mode   in   1          1 = stop after each instruction, wait for step_req
//  step_req    in   1          level; rising edge releases one instruction
//  opcode_in   in   NUM_OPS    one-hot opcode, valid during DECODE
//  flags       in   FLAG_W     flags register, sampled when entering each EXEC step
//  ctrl        out  CTRL_W     registered control word, index 1..CTRL_W
//  busy        out  1          1 in FETCH/DECODE/EXEC
//  instr_done  out  1          1-cycle pulse in the last EXEC step
//  illegal_op  out  1          sticky; set on a bad opcode
//  cur_step    out  STEP_W     current EXEC step index
// BEHAVIOUR
//  - Reset (async): state=IDLE. ctrl=0, busy=0, instr_done=0, illegal_op=0,
//    cur_step=0, latched op=0, step_req edge detector cleared. Abort mid-instruction permitted.
//  - All outputs are registered and load on the same edge as the state transition.
//    ctrl holds the word of the current state for the whole cycle.
//  - IDLE: ctrl=0. run=1 -> FETCH.
//  - FETCH: ctrl=FETCH_WORD (IR load, PC increment). Next state -> DECODE.
//  - DECODE: ctrl=0. Latch opcode_in and encode it to an index.
//    If zero-hot or multi-hot -> FAULT. Otherwise cur_step=0 -> EXEC.
//  - EXEC: ROM(op,step) returns {last, cond_en, cond_sel, cond_pol, word}.
//    ctrl = word, except bits in BRANCH_MASK are cleared when
//    cond_en=1 and flags[cond_sel]!=cond_pol.
//    If last=1 or step==MAX_STEPS-1: set instr_done=1 and pick the next state:
//      step_mode=1 -> WAIT; else run=1 -> FETCH; else IDLE.
//    Otherwise increment cur_step and stay in EXEC.
//  - WAIT: ctrl=0, busy=0. A step_req rising edge -> FETCH (one instruction).
//    A held step_req does not retrigger. step_mode=0 with run=1 -> FETCH.
//    run=0 -> IDLE.
//  - FAULT: ctrl=0, busy=0, illegal_op=1. Exit only via reset.
//  - run=0 mid-instruction: the current instruction completes, then IDLE.
//    No partial instructions.
//  - Latency: run sampled 1 at edge k gives FETCH in cycle k+1, DECODE in k+2,
//    first EXEC in k+3. An N-step instruction takes 2+N cycles.
//  - flags and step_mode are sampled at the same edge as the decision that uses them.
// STRUCTURE
//  - Shared include control_fsm_defs.vh holds:
//    state localparams (IDLE, FETCH, DECODE, EXEC, WAIT, FAULT),
//    FETCH_WORD, BRANCH_MASK, ROM entry field layout, per-opcode microcode table.
//  - Sub-module control_microcode_rom: combinational (op index, step) -> ROM entry.
//  - One-hot validity check and encoder live inline in the sequencer.
// TESTING
//  1. NOOP (op 0, 1 step), run=1: ctrl sequence FETCH_WORD, 0, ROM(0,0).
//     instr_done pulses in cycle 3, repeats every 3 cycles.
//  2. Cond branch, cond_sel=flags[0], cond_pol=1, flags=4'b0001:
//     BRANCH_MASK bits asserted in EXEC. With flags=4'b0000 those bits are 0
//     and all other bits are unchanged.
//  3. opcode_in=0 and opcode_in with bits 3 and 5 set: FAULT, illegal_op=1,
//     ctrl=0, busy=0 held 20 cycles. Reset clears.
//  4. step_mode=1, step_req held high 10 cycles: exactly one instruction, then WAIT.
//     Low->high again releases one more.
//  5. 4-step op, run dropped at step 1: steps 2..3 still execute,
//     instr_done pulses, then IDLE with ctrl=0.
//  6. reset asserted between clock edges during EXEC step 2: ctrl=0 and
//     state=IDLE immediately, with no clock edge needed.

Source files
------------

// File: rtl/multicycle_control_sequencer_pkg.sv
// Shared definitions for the multicycle control sequencer: states, fixed control words,
// microcode entry layout and the per-opcode microcode rules.
package multicycle_control_sequencer_pkg;

   localparam int DEF_NUM_OPS   = 23;
   localparam int DEF_CTRL_W    = 23;
   localparam int DEF_FLAG_W    = 4;
   localparam int DEF_MAX_STEPS = 4;
   localparam int SEL_W         = $clog2(DEF_FLAG_W);

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WAIT, FAULT} state_t;

   // ctrl[1] = IR load, ctrl[2] = PC increment, ctrl[22:23] = PC load / PC source
   localparam logic [DEF_CTRL_W:1] FETCH_WORD  = 23'h000003;
   localparam logic [DEF_CTRL_W:1] BRANCH_MASK = 23'h600000;

   localparam int DP_LO        = 3;
   localparam int DP_BITS      = 19;
   localparam int BRANCH_OP_LO = 16;
   localparam int COND_OP_HI   = 21;
   localparam int POS_POL_HI   = 19;

   typedef struct packed {
      logic                  last;
      logic                  cond_en;
      logic [SEL_W-1:0]      cond_sel;
      logic                  cond_pol;
      logic [DEF_CTRL_W:1]   word;
   } rom_entry_t;

   // Op i runs (i mod max_steps)+1 steps, each step strobes one datapath line.
   // Ops 16..21 are flag-qualified branches, op 22 an unconditional jump.
   function automatic rom_entry_t microcode(input int op, input int step, input int max_steps);
      rom_entry_t e;
      int n;
      n = op % max_steps + 1;
      e = '0;
      e.last = (step >= n - 1);
      if (step < n)
         e.word = e.word | (DEF_CTRL_W'(1) << (DP_LO - 1 + (op * 3 + step) % DP_BITS));
      if (op >= BRANCH_OP_LO) begin
         if (step == n - 1)
            e.word = e.word | BRANCH_MASK;
         e.cond_en  = (op <= COND_OP_HI);
         e.cond_sel = SEL_W'(op % DEF_FLAG_W);
         e.cond_pol = (op <= POS_POL_HI);
      end
      return e;
   endfunction

endpackage

// File: rtl/multicycle_control_sequencer_rom.sv
// Combinational microcode ROM: (op index, step) -> {last, cond_en, cond_sel, cond_pol, word}.
module multicycle_control_sequencer_rom
   import multicycle_control_sequencer_pkg::*;
#(
   parameter int NUM_OPS   = DEF_NUM_OPS,
   parameter int MAX_STEPS = DEF_MAX_STEPS
)(
   input  logic [$clog2(NUM_OPS)-1:0]   op,
   input  logic [$clog2(MAX_STEPS)-1:0] step,
   output logic [$bits(rom_entry_t)-1:0] entry
);

   localparam int DEPTH  = NUM_OPS * MAX_STEPS;
   localparam int ADDR_W = $clog2(DEPTH);

   rom_entry_t        table_rom [DEPTH];
   logic [ADDR_W-1:0] addr;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_table
         assign table_rom[gi] = microcode(gi / MAX_STEPS, gi % MAX_STEPS, MAX_STEPS);
      end
   endgenerate

   assign addr  = ADDR_W'(op) * ADDR_W'(MAX_STEPS) + ADDR_W'(step);
   assign entry = (int'(addr) < DEPTH) ? table_rom[addr] : '0;

endmodule

// File: rtl/multicycle_control_sequencer.sv
// Multicycle CPU control sequencer: FETCH, DECODE and microcoded EXEC steps with
// flag-qualified branches, single-step mode and sticky illegal-opcode trap.
module multicycle_control_sequencer
   import multicycle_control_sequencer_pkg::*;
#(
   parameter int NUM_OPS   = DEF_NUM_OPS,
   parameter int CTRL_W    = DEF_CTRL_W,
   parameter int FLAG_W    = DEF_FLAG_W,
   parameter int MAX_STEPS = DEF_MAX_STEPS
)(
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         run,
   input  logic                         step_mode,
   input  logic                         step_req,
   input  logic [NUM_OPS-1:0]           opcode_in,
   input  logic [FLAG_W-1:0]            flags,
   output logic [CTRL_W:1]              ctrl,
   output logic                         busy,
   output logic                         instr_done,
   output logic                         illegal_op,
   output logic [$clog2(MAX_STEPS)-1:0] cur_step
);

   localparam int                STEP_W    = $clog2(MAX_STEPS);
   localparam int                OP_W      = $clog2(NUM_OPS);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEPS - 1);

   state_t            state_reg, state_next;
   logic [CTRL_W:1]   ctrl_reg, ctrl_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              illegal_reg, illegal_next;
   logic [STEP_W-1:0] step_reg, step_next;
   logic [OP_W-1:0]   op_reg, op_next;
   logic              step_req_prev_reg;

   logic              step_rise;
   logic              op_valid;
   logic [OP_W-1:0]   op_index;
   logic [OP_W-1:0]   op_terms [NUM_OPS];
   logic [$bits(rom_entry_t)-1:0] entry_bits;
   rom_entry_t        entry;
   logic              branch_blocked;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OPS; gi++) begin : g_enc
         assign op_terms[gi] = opcode_in[gi] ? OP_W'(gi) : '0;
      end
   endgenerate

   always_comb begin
      op_index = '0;
      for (int i = 0; i < NUM_OPS; i++)
         op_index = op_index | op_terms[i];
   end

   assign op_valid  = (opcode_in != '0) && ((opcode_in & (opcode_in - NUM_OPS'(1))) == '0);
   assign step_rise = step_req & ~step_req_prev_reg;

   // done_reg is high exactly in the last EXEC step, so it doubles as the exit flag.
   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      step_next  = '0;
      unique case (state_reg)
         IDLE:   if (run) state_next = FETCH;
         FETCH:  state_next = DECODE;
         DECODE: begin
            if (op_valid) begin
               op_next    = op_index;
               state_next = EXEC;
            end else begin
               state_next = FAULT;
            end
         end
         EXEC: begin
            if (done_reg) begin
               if (step_mode)  state_next = WAIT;
               else if (run)   state_next = FETCH;
               else            state_next = IDLE;
            end else begin
               step_next = step_reg + STEP_W'(1);
            end
         end
         WAIT: begin
            if (step_rise)       state_next = FETCH;
            else if (!run)       state_next = IDLE;
            else if (!step_mode) state_next = FETCH;
         end
         FAULT:   state_next = FAULT;
         default: state_next = IDLE;
      endcase
   end

   // The ROM is addressed with the step being entered so its word loads on that edge.
   multicycle_control_sequencer_rom #(
      .NUM_OPS   (NUM_OPS),
      .MAX_STEPS (MAX_STEPS)
   ) u_rom (
      .op    (op_next),
      .step  (step_next),
      .entry (entry_bits)
   );

   assign entry          = entry_bits;
   assign branch_blocked = entry.cond_en && (flags[entry.cond_sel] != entry.cond_pol);

   always_comb begin
      ctrl_next    = '0;
      busy_next    = 1'b0;
      done_next    = 1'b0;
      illegal_next = illegal_reg;
      unique case (state_next)
         FETCH: begin
            ctrl_next = FETCH_WORD;
            busy_next = 1'b1;
         end
         DECODE: busy_next = 1'b1;
         EXEC: begin
            ctrl_next = branch_blocked ? (entry.word & ~BRANCH_MASK) : entry.word;
            busy_next = 1'b1;
            done_next = entry.last || (step_next == LAST_STEP);
         end
         FAULT:   illegal_next = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg         <= IDLE;
         ctrl_reg          <= '0;
         busy_reg          <= 1'b0;
         done_reg          <= 1'b0;
         illegal_reg       <= 1'b0;
         step_reg          <= '0;
         op_reg            <= '0;
         step_req_prev_reg <= 1'b0;
      end else begin
         state_reg         <= state_next;
         ctrl_reg          <= ctrl_next;
         busy_reg          <= busy_next;
         done_reg          <= done_next;
         illegal_reg       <= illegal_next;
         step_reg          <= step_next;
         op_reg            <= op_next;
         step_req_prev_reg <= step_req;
      end
   end

   assign ctrl       = ctrl_reg;
   assign busy       = busy_reg;
   assign instr_done = done_reg;
   assign illegal_op = illegal_reg;
   assign cur_step   = step_reg;

endmodule

// File: tb/tb_multicycle_control_sequencer.sv
// Self-checking bench: directed scenarios plus random instruction stream checked against
// an instruction-level model of the microcode rules.
module tb_multicycle_control_sequencer;

   localparam logic [22:0] FETCH_W = 23'h000003;
   localparam logic [22:0] BR_MASK = 23'h600000;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        step_mode = 1'b0;
   logic        step_req = 1'b0;
   logic [22:0] opcode_in = '0;
   logic [3:0]  flags = '0;
   logic [22:0] ctrl;
   logic        busy;
   logic        instr_done;
   logic        illegal_op;
   logic [1:0]  cur_step;

   int n_pass = 0;
   int n_checks = 0;

   multicycle_control_sequencer #(
      .NUM_OPS   (23),
      .CTRL_W    (23),
      .FLAG_W    (4),
      .MAX_STEPS (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .run        (run),
      .step_mode  (step_mode),
      .step_req   (step_req),
      .opcode_in  (opcode_in),
      .flags      (flags),
      .ctrl       (ctrl),
      .busy       (busy),
      .instr_done (instr_done),
      .illegal_op (illegal_op),
      .cur_step   (cur_step)
   );

   always #5 clock = ~clock;

   function automatic int steps_of(input int op);
      return op % 4 + 1;
   endfunction

   // Expected control word; vector bit j carries ctrl[j+1].
   function automatic logic [22:0] exp_ctrl(input int op, input int s, input logic [3:0] fl);
      logic [22:0] w;
      logic [3:0]  sh;
      logic        taken;
      w = 23'(1) << (2 + (op * 3 + s) % 19);
      if (op >= 16 && s == steps_of(op) - 1) begin
         if (op <= 19) begin
            sh = fl >> (op - 16);
            taken = sh[0];
         end else if (op <= 21) begin
            sh = fl >> (op - 20);
            taken = !sh[0];
         end else begin
            taken = 1'b1;
         end
         if (taken) w = w | BR_MASK;
      end
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check_quiet(input string tag, input logic ill);
      check({tag, " ctrl"}, 32'(ctrl), 32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " done"}, 32'(instr_done), 32'd0);
      check({tag, " illegal"}, 32'(illegal_op), 32'(ill));
   endtask

   // One whole instruction, starting with the edge that should enter FETCH.
   task automatic do_instr(input int op, input bit use_fixed, input logic [3:0] fixed_fl,
                           input int drop_run_at, input int abort_at);
      logic [3:0] fl;
      int n;
      n = steps_of(op);
      opcode_in = 23'($urandom);
      tick;
      check("fetch ctrl", 32'(ctrl), 32'(FETCH_W));
      check("fetch busy", 32'(busy), 32'd1);
      check("fetch done", 32'(instr_done), 32'd0);
      opcode_in = 23'(1) << op;
      tick;
      check("decode ctrl", 32'(ctrl), 32'd0);
      check("decode busy", 32'(busy), 32'd1);
      for (int s = 0; s < n; s++) begin
         fl = use_fixed ? fixed_fl : 4'($urandom);
         flags = fl;
         tick;
         if (s == 0) opcode_in = 23'($urandom);
         check("exec ctrl", 32'(ctrl), 32'(exp_ctrl(op, s, fl)));
         check("exec busy", 32'(busy), 32'd1);
         check("exec done", 32'(instr_done), 32'(s == n - 1));
         check("exec step", 32'(cur_step), 32'(s));
         check("exec illegal", 32'(illegal_op), 32'd0);
         if (s == drop_run_at) run = 1'b0;
         if (s == abort_at) begin
            #2 reset = 1'b1;
            #1;
            check("abort ctrl", 32'(ctrl), 32'd0);
            check("abort busy", 32'(busy), 32'd0);
            check("abort done", 32'(instr_done), 32'd0);
            check("abort step", 32'(cur_step), 32'd0);
            $display("instr op=%0d aborted at step %0d", op, s);
            return;
         end
      end
      $display("instr op=%0d steps=%0d flags=%b", op, n, fl);
   endtask

   initial begin
      #1;
      check_quiet("reset", 1'b0);
      check("reset step", 32'(cur_step), 32'd0);
      run = 1'b1;
      tick;
      check_quiet("reset held", 1'b0);
      reset = 1'b0;

      // NOOP back to back: FETCH_WORD, 0, ROM(0,0) every 3 cycles
      repeat (3) do_instr(0, 1'b0, 4'b0000, -1, -1);

      // Flag-qualified branches, positive and negative polarity
      do_instr(16, 1'b1, 4'b0001, -1, -1);
      do_instr(16, 1'b1, 4'b0000, -1, -1);
      do_instr(20, 1'b1, 4'b0000, -1, -1);
      do_instr(20, 1'b1, 4'b0001, -1, -1);
      do_instr(19, 1'b1, 4'b0111, -1, -1);

      // Random instruction stream with random flags per step
      repeat (16) do_instr(int'($urandom_range(0, 22)), 1'b0, 4'b0000, -1, -1);

      // run dropped during step 1 of a 4-step op: completes, then IDLE
      do_instr(3, 1'b0, 4'b0000, 1, -1);
      repeat (3) begin
         tick;
         check_quiet("idle after drop", 1'b0);
      end

      // Single-step mode
      step_mode = 1'b1;
      run = 1'b1;
      do_instr(5, 1'b0, 4'b0000, -1, -1);
      repeat (4) begin
         tick;
         check_quiet("wait", 1'b0);
      end
      step_req = 1'b1;
      do_instr(6, 1'b0, 4'b0000, -1, -1);
      repeat (5) begin
         tick;
         check_quiet("wait held req", 1'b0);
      end
      step_req = 1'b0;
      tick;
      check_quiet("wait req low", 1'b0);
      step_req = 1'b1;
      do_instr(7, 1'b0, 4'b0000, -1, -1);
      tick;
      check_quiet("wait again", 1'b0);
      step_req = 1'b0;
      run = 1'b0;
      tick;
      check_quiet("wait to idle", 1'b0);
      run = 1'b1;
      do_instr(4, 1'b0, 4'b0000, -1, -1);
      tick;
      check_quiet("wait 3", 1'b0);
      step_mode = 1'b0;
      do_instr(8, 1'b0, 4'b0000, -1, -1);
      run = 1'b0;
      tick;
      check_quiet("idle", 1'b0);

      // Asynchronous reset in EXEC step 2
      run = 1'b1;
      do_instr(3, 1'b0, 4'b0000, -1, 2);
      run = 1'b0;
      #2 reset = 1'b0;
      tick;
      check_quiet("after abort", 1'b0);

      // Illegal opcodes: zero-hot and multi-hot
      for (int k = 0; k < 2; k++) begin
         run = 1'b1;
         opcode_in = (k == 0) ? 23'h0 : 23'h28;
         tick;
         check("bad fetch ctrl", 32'(ctrl), 32'(FETCH_W));
         tick;
         check("bad decode busy", 32'(busy), 32'd1);
         tick;
         repeat (20) begin
            check_quiet("fault", 1'b1);
            run = 1'($urandom);
            step_mode = 1'($urandom);
            step_req = 1'($urandom);
            opcode_in = 23'(1) << $urandom_range(0, 22);
            tick;
         end
         $display("illegal opcode case %0d trapped", k);
         reset = 1'b1;
         #1;
         check_quiet("fault reset", 1'b0);
         run = 1'b0;
         step_mode = 1'b0;
         step_req = 1'b0;
         #3 reset = 1'b0;
         tick;
         check_quiet("fault cleared", 1'b0);
      end

      run = 1'b1;
      do_instr(9, 1'b0, 4'b0000, -1, -1);
      run = 1'b0;
      tick;
      check_quiet("final idle", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
